// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO pin cell and the bank that instantiates it.
//   int_mask_e : encodings of the per-pin IRQ_INT edge select
//   DIR_IN/OUT : values of the per-pin direction control
//   int_hit()  : tells whether a rise/fall event matches an edge select
package gpio_pkg;

  typedef enum logic [1:0] {
    INT_NONE = 2'b00,
    INT_RISE = 2'b01,
    INT_FALL = 2'b10,
    INT_BOTH = 2'b11
  } int_mask_e;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  // Bit 0 of the select enables rising edges, bit 1 enables falling edges.
  function automatic logic int_hit(input logic [1:0] mask,
                                   input logic       rise,
                                   input logic       fall);
    return (mask[0] & rise) | (mask[1] & fall);
  endfunction

endpackage

// File: rtl/gpio_edge_detect.sv
// Pad input synchronizer, edge detector and registered IRQ pulse generator.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   pad_in          raw pad level (asynchronous to clk)
//   active          cell currently enabled and in input mode
//   irq_en          pin-change interrupts enabled
//   int_mask        IRQ_INT edge select (see gpio_pkg::int_mask_e)
//   sync_out        synchronized pad level (last synchronizer stage)
//   irq_pin_change  one-cycle pulse on any qualified edge
//   irq_int         one-cycle pulse on a qualified edge matching int_mask
// SYNC_STAGES must be 2 or more.
module gpio_edge_detect
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pad_in,
  input  logic       active,
  input  logic       irq_en,
  input  logic [1:0] int_mask,
  output logic       sync_out,
  output logic       irq_pin_change,
  output logic       irq_int
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_reg;
  logic                   active_prev;
  logic                   rise;
  logic                   fall;
  logic                   qual;

  // Synchronizer stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  assign rise = sync_out & ~prev_reg;
  assign fall = ~sync_out & prev_reg;

  // active_prev blocks the first cycle after entering input mode or
  // re-enabling, so a level left over from output mode or from the
  // disabled state never shows up as an edge.
  assign qual = active & active_prev & irq_en;

  // Edge history and IRQ pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg       <= 1'b0;
      active_prev    <= 1'b0;
      irq_pin_change <= 1'b0;
      irq_int        <= 1'b0;
    end else begin
      prev_reg       <= sync_out;
      active_prev    <= active;
      irq_pin_change <= qual & (rise | fall);
      irq_int        <= qual & int_hit(int_mask, rise, fall);
    end
  end

endmodule

// File: rtl/gpio_single.sv
// Single bidirectional GPIO pin cell.
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   PIN_DATA         pad; driven in output mode, high-Z otherwise
//   Enable           active-low cell enable (1 = disabled)
//   Function         direction, DIR_IN (0) or DIR_OUT (1)
//   Data_out         value driven on the pad in output mode
//   Pin_Change_Mask  1 = interrupts enabled for this pin
//   Int_Mask         IRQ_INT edge select (none / rise / fall / both)
//   Data_in          synchronized pad value, 0 while disabled
//   Pin_out          value currently driven to the pad, 0 when not driving
//   IRQ_PIN_CHANGE   one-cycle pulse on any qualified pin edge
//   IRQ_INT          one-cycle pulse on a qualified edge matching Int_Mask
module gpio_single
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        PIN_DATA,
  input  logic       Enable,
  input  logic       Function,
  input  logic       Data_out,
  input  logic       Pin_Change_Mask,
  input  logic [1:0] Int_Mask,
  output logic       Data_in,
  output logic       Pin_out,
  output logic       IRQ_PIN_CHANGE,
  output logic       IRQ_INT
);

  logic       function_reg;
  logic       enable_reg;
  logic       pin_change_mask_reg;
  logic [1:0] int_mask_reg;
  logic       data_out_reg;
  logic       drive;
  logic       active;
  logic       sync_in;

  // Control registers; the reset value means enabled, input mode, IRQs off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      function_reg        <= DIR_IN;
      enable_reg          <= 1'b0;
      pin_change_mask_reg <= 1'b0;
      int_mask_reg        <= INT_NONE;
      data_out_reg        <= 1'b0;
    end else begin
      function_reg        <= Function;
      enable_reg          <= Enable;
      pin_change_mask_reg <= Pin_Change_Mask;
      int_mask_reg        <= Int_Mask;
      data_out_reg        <= Data_out;
    end
  end

  assign drive  = ~enable_reg & (function_reg == DIR_OUT);
  assign active = ~enable_reg & (function_reg == DIR_IN);

  assign PIN_DATA = drive ? data_out_reg : 1'bz;
  assign Pin_out  = drive & data_out_reg;

  // The synchronizer keeps sampling the pad in output mode, which gives
  // readback of the driven level on Data_in.
  gpio_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .clk            (clk),
    .rst            (reset),
    .pad_in         (PIN_DATA),
    .active         (active),
    .irq_en         (pin_change_mask_reg),
    .int_mask       (int_mask_reg),
    .sync_out       (sync_in),
    .irq_pin_change (IRQ_PIN_CHANGE),
    .irq_int        (IRQ_INT)
  );

  assign Data_in = ~enable_reg & sync_in;

endmodule

// File: tb/tb_gpio_single.sv
module tb_gpio_single;
  import gpio_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       tb_oe;
  logic       tb_val;
  wire        pad;
  logic       Enable;
  logic       Function;
  logic       Data_out;
  logic       Pin_Change_Mask;
  logic [1:0] Int_Mask;
  logic       Data_in;
  logic       Pin_out;
  logic       IRQ_PIN_CHANGE;
  logic       IRQ_INT;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int   at;
    logic pc;
    logic it;
  } exp_t;

  exp_t sb[$];

  assign pad = tb_oe ? tb_val : 1'bz;

  always #5 clk = ~clk;

  gpio_single #(
    .SYNC_STAGES (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .PIN_DATA        (pad),
    .Enable          (Enable),
    .Function        (Function),
    .Data_out        (Data_out),
    .Pin_Change_Mask (Pin_Change_Mask),
    .Int_Mask        (Int_Mask),
    .Data_in         (Data_in),
    .Pin_out         (Pin_out),
    .IRQ_PIN_CHANGE  (IRQ_PIN_CHANGE),
    .IRQ_INT         (IRQ_INT)
  );

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock, sampled 1 time unit after the rising edge; IRQ outputs are
  // checked every cycle against the scoreboard (idle cycles expect 0).
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      chk("irq_pin_change", IRQ_PIN_CHANGE, e.pc);
      chk("irq_int", IRQ_INT, e.it);
    end else begin
      chk("irq_pin_change_idle", IRQ_PIN_CHANGE, 1'b0);
      chk("irq_int_idle", IRQ_INT, 1'b0);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Drive a new pad level from the bench and, if it is an edge, queue the
  // IRQ outputs expected 3 clocks later given the current (settled) config.
  task automatic pad_set(input logic v);
    logic r;
    logic f;
    logic q;
    r = v & ~tb_val;
    f = ~v & tb_val;
    q = (Enable == 1'b0) && (Function == DIR_IN) && (Pin_Change_Mask == 1'b1);
    if (r | f)
      sb.push_back('{cyc + 3, q, q & ((Int_Mask[0] & r) | (Int_Mask[1] & f))});
    tb_val = v;
  endtask

  initial begin
    // Reset with non-default port values
    reset           = 1'b1;
    tb_oe           = 1'b1;
    tb_val          = 1'b1;
    Enable          = 1'b0;
    Function        = DIR_OUT;
    Data_out        = 1'b1;
    Pin_Change_Mask = 1'b1;
    Int_Mask        = INT_BOTH;
    #1;
    chk("rst_async_pin_out", Pin_out, 1'b0);
    chk("rst_async_irq_pc", IRQ_PIN_CHANGE, 1'b0);
    ticks(2);
    chk("rst_pin_out", Pin_out, 1'b0);
    chk("rst_data_in", Data_in, 1'b0);
    chk("rst_pad_released", pad, 1'b1);
    reset = 1'b0;
    tick();
    chk("post_rst_pin_out", Pin_out, 1'b1);
    chk("post_rst_pad", pad, 1'b1);

    // Output mode and readback
    tb_oe    = 1'b0;
    Data_out = 1'b0;
    tick();
    chk("out0_pin_out", Pin_out, 1'b0);
    chk("out0_pad", pad, 1'b0);
    tick();
    chk("readback_old", Data_in, 1'b1);
    tick();
    chk("readback_new", Data_in, 1'b0);
    Data_out = 1'b1;
    tick();
    chk("out1_pin_out", Pin_out, 1'b1);
    chk("out1_pad", pad, 1'b1);
    Data_out = 1'b0;
    tick();
    chk("out2_pin_out", Pin_out, 1'b0);
    chk("out2_pad", pad, 1'b0);

    // Disabled cell: pad released, Pin_out and Data_in forced to 0
    Enable   = 1'b1;
    Data_out = 1'b1;
    tb_oe    = 1'b1;
    tb_val   = 1'b0;
    tick();
    chk("dis_pin_out", Pin_out, 1'b0);
    chk("dis_pad_released", pad, 1'b0);
    pad_set(1'b1);
    ticks(2);
    chk("dis_data_in_forced", Data_in, 1'b0);
    Enable = 1'b0;
    tick();
    chk("reen_pin_out", Pin_out, 1'b1);
    chk("reen_pad", pad, 1'b1);

    // Input mode, rising-edge select
    Function = DIR_IN;
    Int_Mask = INT_RISE;
    ticks(2);
    pad_set(1'b0);
    tick();
    chk("in_hold1", Data_in, 1'b1);
    tick();
    chk("in_fall", Data_in, 1'b0);
    chk("in_pin_out", Pin_out, 1'b0);
    pad_set(1'b1);
    tick();
    chk("in_hold0", Data_in, 1'b0);
    tick();
    chk("in_rise", Data_in, 1'b1);
    pad_set(1'b0);
    tick();
    chk("in_hold1b", Data_in, 1'b1);
    tick();
    chk("in_fall_b", Data_in, 1'b0);

    // Falling-edge select
    Int_Mask = INT_FALL;
    pad_set(1'b1);
    ticks(2);
    pad_set(1'b0);
    ticks(2);

    // Both edges, back-to-back
    Int_Mask = INT_BOTH;
    pad_set(1'b1);
    tick();
    pad_set(1'b0);
    ticks(3);

    // Pin-change interrupts disabled
    Pin_Change_Mask = 1'b0;
    pad_set(1'b1);
    ticks(2);
    pad_set(1'b0);
    ticks(3);

    // Output-mode gating, then return to input mode at the same level
    Pin_Change_Mask = 1'b1;
    Int_Mask        = INT_BOTH;
    Function        = DIR_OUT;
    Data_out        = 1'b0;
    tick();
    tb_oe    = 1'b0;
    Data_out = 1'b1;
    tick();
    chk("gate_pin_out1", Pin_out, 1'b1);
    chk("gate_pad1", pad, 1'b1);
    Data_out = 1'b0;
    tick();
    chk("gate_pin_out0", Pin_out, 1'b0);
    chk("gate_pad0", pad, 1'b0);
    ticks(2);
    tb_oe    = 1'b1;
    tb_val   = 1'b0;
    Function = DIR_IN;
    ticks(4);

    // Reset mid-operation drops the pulse in flight
    pad_set(1'b1);
    ticks(2);
    chk("mid_data_in", Data_in, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_data_in", Data_in, 1'b0);
    chk("mid_rst_irq_pc", IRQ_PIN_CHANGE, 1'b0);
    chk("mid_rst_irq_int", IRQ_INT, 1'b0);
    sb.delete();
    ticks(2);
    reset = 1'b0;
    tick();
    chk("sb_drained", (sb.size() == 0), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
